// File: rtl/mem_ctrl_if.sv
// Bus bundle between mem_ctrl and its environment: RAM port, fetch/load request ports, store commit.
interface mem_ctrl_if;
   localparam int unsigned AW = 32;
   localparam int unsigned DW = 32;
   localparam int unsigned BW = 8;

   logic          rdy;
   logic          clear;
   logic [BW-1:0] mem_din;
   logic [BW-1:0] mem_dout;
   logic [AW-1:0] mem_a;
   logic          mem_wr;
   logic          if_req;
   logic [AW-1:0] if_addr;
   logic          if_done;
   logic [DW-1:0] if_data;
   logic          ld_req;
   logic [AW-1:0] ld_addr;
   logic [1:0]    ld_size;
   logic          ld_done;
   logic [DW-1:0] ld_data;
   logic          rob_store_sgn;
   logic [AW-1:0] st_addr;
   logic [DW-1:0] st_data;
   logic [1:0]    st_size;
   logic          finish_store;

   // Environment side: RAM model, fetch unit, load unit, ROB
   modport master (
      output rdy, clear, mem_din,
      output if_req, if_addr, ld_req, ld_addr, ld_size,
      output rob_store_sgn, st_addr, st_data, st_size,
      input  mem_dout, mem_a, mem_wr,
      input  if_done, if_data, ld_done, ld_data, finish_store
   );

   // Controller side
   modport slave (
      input  rdy, clear, mem_din,
      input  if_req, if_addr, ld_req, ld_addr, ld_size,
      input  rob_store_sgn, st_addr, st_data, st_size,
      output mem_dout, mem_a, mem_wr,
      output if_done, if_data, ld_done, ld_data, finish_store
   );
endinterface

// File: rtl/mem_ctrl.sv
// Byte-serial memory controller arbitrating committed stores, loads and instruction fetches
// onto a single 8-bit synchronous RAM port.
module mem_ctrl (
   input  logic       clk,
   input  logic       rst,
   mem_ctrl_if.slave  bus
);
   localparam int unsigned AW = 32;
   localparam int unsigned DW = 32;
   localparam int unsigned BW = 8;
   localparam int unsigned CW = 3;

   typedef enum logic [1:0] {IDLE, FETCH, LOAD, STORE} state_t;

   state_t        state_q, state_d;
   logic [CW-1:0] cnt_q, cnt_d;
   logic [CW-1:0] rd_n_q, rd_n_d;
   logic [DW-1:0] rd_buf_q, rd_buf_d;
   logic          st_pending_q, st_pending_d;
   logic [AW-1:0] st_addr_q, st_addr_d;
   logic [DW-1:0] st_data_q, st_data_d;
   logic [1:0]    st_size_q, st_size_d;
   logic [AW-1:0] mem_a_q, mem_a_d;
   logic [BW-1:0] mem_dout_q, mem_dout_d;
   logic          mem_wr_q, mem_wr_d;
   logic          if_done_q, if_done_d;
   logic [DW-1:0] if_data_q, if_data_d;
   logic          ld_done_q, ld_done_d;
   logic [DW-1:0] ld_data_q, ld_data_d;
   logic          finish_store_q, finish_store_d;

   logic [CW-1:0] st_n_c;
   logic [CW-1:0] nxt_idx_c;
   logic [CW-1:0] rd_idx_c;
   logic [DW-1:0] rd_merge_c;
   logic [BW-1:0] st_byte_c;

   // Size code to byte count; code 3 is treated as a word
   function automatic logic [CW-1:0] size_to_n(input logic [1:0] size);
      case (size)
         2'd0:    return CW'(1);
         2'd1:    return CW'(2);
         default: return CW'(4);
      endcase
   endfunction

   // Byte lane helpers: next byte index, byte arriving on mem_din now, next store byte
   assign st_n_c     = size_to_n(st_size_q);
   assign nxt_idx_c  = cnt_q + CW'(1);
   assign rd_idx_c   = cnt_q - CW'(1);
   assign rd_merge_c = rd_buf_q | (DW'(bus.mem_din) << {rd_idx_c, 3'b000});
   assign st_byte_c  = BW'(st_data_q >> {nxt_idx_c, 3'b000});

   // Next-state: arbitration, byte sequencing, flush and freeze
   always_comb begin
      state_d        = state_q;
      cnt_d          = cnt_q;
      rd_n_d         = rd_n_q;
      rd_buf_d       = rd_buf_q;
      st_pending_d   = st_pending_q;
      st_addr_d      = st_addr_q;
      st_data_d      = st_data_q;
      st_size_d      = st_size_q;
      mem_a_d        = mem_a_q;
      mem_dout_d     = mem_dout_q;
      mem_wr_d       = 1'b0;
      if_done_d      = 1'b0;
      if_data_d      = if_data_q;
      ld_done_d      = 1'b0;
      ld_data_d      = ld_data_q;
      finish_store_d = 1'b0;

      if (bus.rdy) begin
         // Only one store can be outstanding; the ROB waits for finish_store
         if (bus.rob_store_sgn && !st_pending_q) begin
            st_pending_d = 1'b1;
            st_addr_d    = bus.st_addr;
            st_data_d    = bus.st_data;
            st_size_d    = bus.st_size;
         end

         case (state_q)
            IDLE: begin
               cnt_d = '0;
               if (st_pending_q) begin
                  state_d    = STORE;
                  mem_a_d    = st_addr_q;
                  mem_dout_d = st_data_q[BW-1:0];
                  mem_wr_d   = 1'b1;
               end else if (!bus.clear && bus.ld_req) begin
                  state_d  = LOAD;
                  rd_n_d   = size_to_n(bus.ld_size);
                  mem_a_d  = bus.ld_addr;
                  rd_buf_d = '0;
               end else if (!bus.clear && bus.if_req) begin
                  state_d  = FETCH;
                  rd_n_d   = CW'(4);
                  mem_a_d  = bus.if_addr;
                  rd_buf_d = '0;
               end
            end

            FETCH, LOAD: begin
               if (bus.clear) begin
                  state_d = IDLE;
                  cnt_d   = '0;
               end else begin
                  cnt_d = nxt_idx_c;
                  if (nxt_idx_c < rd_n_q) begin
                     mem_a_d = mem_a_q + AW'(1);
                  end
                  if (cnt_q != '0) begin
                     rd_buf_d = rd_merge_c;
                  end
                  if (cnt_q == rd_n_q) begin
                     state_d = IDLE;
                     cnt_d   = '0;
                     if (state_q == FETCH) begin
                        if_done_d = 1'b1;
                        if_data_d = rd_merge_c;
                     end else begin
                        ld_done_d = 1'b1;
                        ld_data_d = rd_merge_c;
                     end
                  end
               end
            end

            STORE: begin
               if (nxt_idx_c < st_n_c) begin
                  cnt_d      = nxt_idx_c;
                  mem_a_d    = mem_a_q + AW'(1);
                  mem_dout_d = st_byte_c;
                  mem_wr_d   = 1'b1;
               end else begin
                  state_d        = IDLE;
                  cnt_d          = '0;
                  st_pending_d   = 1'b0;
                  finish_store_d = 1'b1;
               end
            end
         endcase
      end
   end

   // State and output registers
   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         state_q        <= IDLE;
         cnt_q          <= '0;
         rd_n_q         <= '0;
         rd_buf_q       <= '0;
         st_pending_q   <= 1'b0;
         st_addr_q      <= '0;
         st_data_q      <= '0;
         st_size_q      <= '0;
         mem_a_q        <= '0;
         mem_dout_q     <= '0;
         mem_wr_q       <= 1'b0;
         if_done_q      <= 1'b0;
         if_data_q      <= '0;
         ld_done_q      <= 1'b0;
         ld_data_q      <= '0;
         finish_store_q <= 1'b0;
      end else begin
         state_q        <= state_d;
         cnt_q          <= cnt_d;
         rd_n_q         <= rd_n_d;
         rd_buf_q       <= rd_buf_d;
         st_pending_q   <= st_pending_d;
         st_addr_q      <= st_addr_d;
         st_data_q      <= st_data_d;
         st_size_q      <= st_size_d;
         mem_a_q        <= mem_a_d;
         mem_dout_q     <= mem_dout_d;
         mem_wr_q       <= mem_wr_d;
         if_done_q      <= if_done_d;
         if_data_q      <= if_data_d;
         ld_done_q      <= ld_done_d;
         ld_data_q      <= ld_data_d;
         finish_store_q <= finish_store_d;
      end
   end

   assign bus.mem_a        = mem_a_q;
   assign bus.mem_dout     = mem_dout_q;
   assign bus.mem_wr       = mem_wr_q;
   assign bus.if_done      = if_done_q;
   assign bus.if_data      = if_data_q;
   assign bus.ld_done      = ld_done_q;
   assign bus.ld_data      = ld_data_q;
   assign bus.finish_store = finish_store_q;
endmodule

// File: tb/tb_mem_ctrl.sv
// Scoreboard bench for mem_ctrl: stimulus pushes expected events, a negedge monitor pops and compares.
module tb_mem_ctrl;
   logic clk = 1'b0;
   logic rst;
   always #5 clk = ~clk;

   mem_ctrl_if bus ();

   mem_ctrl dut (
      .clk (clk),
      .rst (rst),
      .bus (bus)
   );

   int unsigned cyc = 0;
   always @(posedge clk) cyc <= cyc + 1;

   typedef struct {
      logic [31:0] a;
      logic [31:0] d;
      int unsigned cyc;
   } exp_t;

   exp_t q_if[$];
   exp_t q_ld[$];
   exp_t q_wr[$];
   exp_t q_fs[$];

   int errors = 0;
   int checks = 0;

   // RAM contents before any store
   function automatic logic [7:0] init_byte(input logic [31:0] a);
      case (a)
         32'h0000_0100: return 8'h13;
         32'h0000_0101: return 8'h05;
         32'h0000_0102: return 8'hA0;
         32'h0000_0103: return 8'h00;
         32'hFFFF_FFFF: return 8'h80;
         32'h0000_0000: return 8'h5A;
         default:       return 8'h00;
      endcase
   endfunction

   logic [7:0] ram [logic [31:0]];

   function automatic logic [7:0] rd_byte(input logic [31:0] a);
      if (ram.exists(a)) return ram[a];
      return init_byte(a);
   endfunction

   // Synchronous RAM: data for the address presented appears after the next edge
   always @(posedge clk) begin
      bus.mem_din <= rd_byte(bus.mem_a);
      if (bus.mem_wr) ram[bus.mem_a] = bus.mem_dout;
   end

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s @cyc %0d: got 0x%08h required 0x%08h", name, cyc, act, exp);
      end
   endtask

   // Monitor: every DUT output event must match the head of its queue
   always @(negedge clk) begin
      exp_t e;
      if (rst === 1'b1) begin
         if (bus.if_done) begin
            if (q_if.size() == 0) chk("if_done_unexpected", 32'd1, 32'd0);
            else begin
               e = q_if.pop_front();
               chk("if_data", bus.if_data, e.d);
               chk("if_done_cycle", cyc, e.cyc);
            end
         end
         if (bus.ld_done) begin
            if (q_ld.size() == 0) chk("ld_done_unexpected", 32'd1, 32'd0);
            else begin
               e = q_ld.pop_front();
               chk("ld_data", bus.ld_data, e.d);
               chk("ld_done_cycle", cyc, e.cyc);
            end
         end
         if (bus.mem_wr) begin
            if (q_wr.size() == 0) chk("mem_wr_unexpected", 32'd1, 32'd0);
            else begin
               e = q_wr.pop_front();
               chk("wr_addr", bus.mem_a, e.a);
               chk("wr_byte", 32'(bus.mem_dout), e.d);
               chk("wr_cycle", cyc, e.cyc);
            end
         end
         if (bus.finish_store) begin
            if (q_fs.size() == 0) chk("finish_unexpected", 32'd1, 32'd0);
            else begin
               e = q_fs.pop_front();
               chk("finish_mem_a", bus.mem_a, e.a);
               chk("finish_cycle", cyc, e.cyc);
            end
         end
      end
   end

   // Fetch (fetch=1) or load request; clr_idle raises clear for the first edge to delay the grant
   task automatic do_read(input bit fetch, input logic [31:0] addr, input logic [1:0] size,
                          input logic [31:0] exp, input bit clr_idle);
      exp_t e;
      int unsigned n;
      int i;
      bit seen;
      n = fetch ? 4 : (size == 2'd0 ? 1 : (size == 2'd1 ? 2 : 4));
      e.a = addr;
      e.d = exp;
      e.cyc = cyc + 1 + (clr_idle ? 1 : 0) + n + 1;
      if (fetch) begin
         q_if.push_back(e);
         bus.if_req  = 1'b1;
         bus.if_addr = addr;
      end else begin
         q_ld.push_back(e);
         bus.ld_req  = 1'b1;
         bus.ld_addr = addr;
         bus.ld_size = size;
      end
      if (clr_idle) bus.clear = 1'b1;
      seen = 1'b0;
      i = 0;
      while (!seen && i < 40) begin
         @(negedge clk);
         bus.clear = 1'b0;
         if (fetch ? bus.if_done : bus.ld_done) seen = 1'b1;
         i++;
      end
      bus.if_req = 1'b0;
      bus.ld_req = 1'b0;
      if (!seen) chk("read_timeout", 32'd0, 32'd1);
   endtask

   // Store commit; stall freezes rdy after byte 0, clr holds clear high during the store
   task automatic do_store(input logic [31:0] addr, input logic [31:0] data, input logic [1:0] size,
                           input int unsigned stall, input bit clr);
      exp_t e;
      int unsigned n;
      int unsigned c0;
      int i;
      bit seen;
      n = (size == 2'd0) ? 1 : ((size == 2'd1) ? 2 : 4);
      c0 = cyc;
      for (int k = 0; k < int'(n); k++) begin
         e.a = addr + 32'(k);
         e.d = (data >> (8 * k)) & 32'hFF;
         e.cyc = c0 + 2 + 32'(k) + ((k > 0) ? stall : 0);
         q_wr.push_back(e);
      end
      e.a = addr + 32'(n - 1);
      e.d = 32'd0;
      e.cyc = c0 + 2 + n + stall;
      q_fs.push_back(e);
      bus.rob_store_sgn = 1'b1;
      bus.st_addr = addr;
      bus.st_data = data;
      bus.st_size = size;
      @(negedge clk);
      bus.rob_store_sgn = 1'b0;
      @(negedge clk);
      if (clr) bus.clear = 1'b1;
      if (stall > 0) begin
         bus.rdy = 1'b0;
         for (int s = 0; s < int'(stall); s++) begin
            @(negedge clk);
            chk("mem_wr_frozen", 32'(bus.mem_wr), 32'd0);
         end
         bus.rdy = 1'b1;
      end
      seen = 1'b0;
      i = 0;
      while (!seen && i < 40) begin
         @(negedge clk);
         if (bus.finish_store) seen = 1'b1;
         i++;
      end
      bus.clear = 1'b0;
      if (!seen) chk("store_timeout", 32'd0, 32'd1);
   endtask

   initial begin
      exp_t e;
      int unsigned c0;
      int i;
      rst = 1'b0;
      bus.rdy = 1'b1;
      bus.clear = 1'b0;
      bus.if_req = 1'b0;
      bus.if_addr = '0;
      bus.ld_req = 1'b0;
      bus.ld_addr = '0;
      bus.ld_size = '0;
      bus.rob_store_sgn = 1'b0;
      bus.st_addr = '0;
      bus.st_data = '0;
      bus.st_size = '0;

      // Reset state
      repeat (2) @(negedge clk);
      chk("rst_mem_a", bus.mem_a, 32'd0);
      chk("rst_mem_dout", 32'(bus.mem_dout), 32'd0);
      chk("rst_mem_wr", 32'(bus.mem_wr), 32'd0);
      chk("rst_if_done", 32'(bus.if_done), 32'd0);
      chk("rst_ld_done", 32'(bus.ld_done), 32'd0);
      chk("rst_finish", 32'(bus.finish_store), 32'd0);
      chk("rst_if_data", bus.if_data, 32'd0);
      chk("rst_ld_data", bus.ld_data, 32'd0);
      rst = 1'b1;
      @(negedge clk);

      // Basic fetch
      do_read(1'b1, 32'h100, 2'd2, 32'h00A00513, 1'b0);

      // Word store then read-back, plus sub-word loads
      do_store(32'h200, 32'hDEADBEEF, 2'd2, 0, 1'b0);
      do_read(1'b0, 32'h200, 2'd2, 32'hDEADBEEF, 1'b0);
      do_read(1'b0, 32'h200, 2'd0, 32'h000000EF, 1'b0);
      do_read(1'b0, 32'h202, 2'd1, 32'h0000DEAD, 1'b0);

      // Contention: pending store, load and fetch all waiting
      c0 = cyc;
      e = '{a: 32'h300, d: 32'h44, cyc: c0 + 2};      q_wr.push_back(e);
      e = '{a: 32'h301, d: 32'h33, cyc: c0 + 3};      q_wr.push_back(e);
      e = '{a: 32'h301, d: 32'h0, cyc: c0 + 4};       q_fs.push_back(e);
      e = '{a: 32'h200, d: 32'hDEADBEEF, cyc: c0 + 10}; q_ld.push_back(e);
      e = '{a: 32'h100, d: 32'h00A00513, cyc: c0 + 16}; q_if.push_back(e);
      bus.rob_store_sgn = 1'b1;
      bus.st_addr = 32'h300;
      bus.st_data = 32'h11223344;
      bus.st_size = 2'd1;
      @(negedge clk);
      bus.rob_store_sgn = 1'b0;
      bus.ld_req = 1'b1;
      bus.ld_addr = 32'h200;
      bus.ld_size = 2'd2;
      bus.if_req = 1'b1;
      bus.if_addr = 32'h100;
      i = 0;
      while ((bus.ld_req || bus.if_req) && i < 40) begin
         @(negedge clk);
         if (bus.ld_done) bus.ld_req = 1'b0;
         if (bus.if_done) bus.if_req = 1'b0;
         i++;
      end
      if (bus.ld_req || bus.if_req) chk("contention_timeout", 32'd0, 32'd1);
      bus.ld_req = 1'b0;
      bus.if_req = 1'b0;
      @(negedge clk);

      // Flush on second fetch cycle: aborted, address frozen, next grant immediate
      bus.if_req = 1'b1;
      bus.if_addr = 32'h100;
      repeat (2) @(negedge clk);
      bus.clear = 1'b1;
      bus.if_req = 1'b0;
      @(negedge clk);
      bus.clear = 1'b0;
      chk("flush_mem_a", bus.mem_a, 32'h101);
      do_read(1'b0, 32'h100, 2'd0, 32'h00000013, 1'b0);

      // clear in IDLE delays a load grant by one edge
      do_read(1'b0, 32'h101, 2'd1, 32'h0000A005, 1'b1);

      // clear throughout a store has no effect on it
      do_store(32'h400, 32'hCAFEF00D, 2'd2, 0, 1'b1);
      do_read(1'b0, 32'h400, 2'd2, 32'hCAFEF00D, 1'b0);

      // Address wrap at the top of the space
      do_read(1'b0, 32'hFFFFFFFF, 2'd0, 32'h00000080, 1'b0);
      do_read(1'b0, 32'hFFFFFFFF, 2'd1, 32'h00005A80, 1'b0);
      do_read(1'b1, 32'hFFFFFFFE, 2'd2, 32'h005A8000, 1'b0);

      // rdy low for three cycles mid-store
      do_store(32'h500, 32'h0A0B0C0D, 2'd2, 3, 1'b0);
      do_read(1'b0, 32'h500, 2'd2, 32'h0A0B0C0D, 1'b0);
      chk("if_data_hold", bus.if_data, 32'h005A8000);

      // Reset in the middle of a fetch abandons it
      @(negedge clk);
      bus.if_req = 1'b1;
      bus.if_addr = 32'h100;
      repeat (2) @(negedge clk);
      rst = 1'b0;
      #1;
      chk("midrst_mem_a", bus.mem_a, 32'd0);
      chk("midrst_if_data", bus.if_data, 32'd0);
      chk("midrst_ld_data", bus.ld_data, 32'd0);
      @(negedge clk);
      chk("midrst_if_done", 32'(bus.if_done), 32'd0);
      rst = 1'b1;
      do_read(1'b1, 32'h100, 2'd2, 32'h00A00513, 1'b0);

      repeat (5) @(negedge clk);
      chk("q_if_empty", 32'(q_if.size()), 32'd0);
      chk("q_ld_empty", 32'(q_ld.size()), 32'd0);
      chk("q_wr_empty", 32'(q_wr.size()), 32'd0);
      chk("q_fs_empty", 32'(q_fs.size()), 32'd0);

      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end
endmodule

// File: doc/mem_ctrl.md
MEM_CTRL -- requirements
Module: mem_ctrl

Interface
REQ-001 The block SHALL use one clock and an asynchronous, active-low reset: clk rising-edge; rst asserted low, effective immediately, independent of clk.
REQ-002 Ports, in order (name direction width meaning):
 clk  in  1  system clock
 rst  in  1  async active-low reset
 rdy  in  1  global enable; low = freeze
 clear  in  1  pipeline flush (mispredict)
 mem_din  in  8  RAM read byte, valid the cycle after its address is presented
 mem_dout  out  8  RAM write byte
 mem_a  out  32  RAM byte address
 mem_wr  out  1  1 = write mem_dout at mem_a
 if_req  in  1  fetch request, level, held until if_done
 if_addr  in  32  fetch address, word read
 if_done  out  1  one-cycle pulse, if_data valid
 if_data  out  32  fetched word, little-endian
 ld_req  in  1  load request, level, held until ld_done
 ld_addr  in  32  load address
 ld_size  in  2  0 = 1 byte, 1 = 2 bytes, 2 = 4 bytes
 ld_done  out  1  one-cycle pulse, ld_data valid
 ld_data  out  32  zero-extended raw load bytes
 rob_store_sgn  in  1  one-cycle store-commit pulse
 st_addr  in  32  store address, sampled with rob_store_sgn
 st_data  in  32  store data, sampled with rob_store_sgn
 st_size  in  2  size encoding as ld_size
 finish_store  out  1  one-cycle pulse, store fully written

Function
REQ-003 FSM states: IDLE, FETCH, LOAD, STORE; byte counter cnt[2:0]; byte count N = 1, 2 or 4 from size.
REQ-004 On rob_store_sgn, the block SHALL latch st_addr/st_data/st_size and set st_pending, in any state.
REQ-005 In IDLE, grant priority SHALL be st_pending > ld_req > if_req; grant registered at that edge; no grant when all idle.
REQ-006 Arbitration SHALL be non-preemptive: a granted transfer runs to completion unless aborted per REQ-011.
REQ-007 Read (FETCH/LOAD), grant edge t: mem_a = addr + k registered at edge t+k (k = 0..N-1); byte k sampled from mem_din at edge t+k+2 into bits [8k+7:8k].
REQ-008 Read completion: at edge t+N+1 the done pulse (if_done or ld_done) SHALL rise with data, state -> IDLE; ld_data upper unread bytes = 0.
REQ-009 STORE, grant edge t: at edge t+k, mem_a = st_addr + k, mem_dout = st_data[8k+7:8k], mem_wr = 1 (k = 0..N-1); at edge t+N mem_wr = 0, finish_store = 1, st_pending cleared, state -> IDLE.
REQ-010 mem_wr SHALL be 1 only during STORE byte cycles; 0 in IDLE, FETCH, LOAD.
REQ-011 clear high in FETCH or LOAD: abort at that edge, no done pulse, state -> IDLE, mem_a unchanged; clear in IDLE blocks fetch/load grants that edge.
REQ-012 clear SHALL NOT affect STORE or st_pending: committed stores always complete and pulse finish_store.
REQ-013 A rob_store_sgn during STORE SHALL be ignored (ROB serialises stores via finish_store); one pending store at most.
REQ-014 rdy low: all state, counters, pending flags and outputs hold; mem_wr forced 0; done pulses do not repeat.
REQ-015 Done pulses SHALL last exactly one cycle; if_data/ld_data hold until the next completion.
REQ-016 IDLE lasts at least one cycle between transfers; back-to-back grant earliest at edge after completion.
REQ-017 Address arithmetic SHALL be 32-bit modulo 2^32 (0xFFFFFFFF + 1 -> 0x00000000).

Reset
REQ-018 While rst low: state = IDLE, cnt = 0, st_pending = 0, mem_a = 0, mem_dout = 0, mem_wr = 0, all done pulses 0, if_data = ld_data = 0, latched store fields = 0.
REQ-019 Reset mid-transfer SHALL abandon it silently (no done, no further writes); first grant possible at first clk edge after rst deasserts.

Verification
REQ-020 Fetch: RAM[0x100..0x103] = 13 05 A0 00, if_req at 0x100 -> if_done 5 edges after grant, if_data = 0x00A00513.
REQ-021 Store word: rob_store_sgn, addr 0x200, data 0xDEADBEEF, size 2 -> writes EF BE AD DE to 0x200..0x203, finish_store after 4 edges; ld size 2 of 0x200 returns 0xDEADBEEF.
REQ-022 Contention: st_pending, ld_req, if_req same cycle -> order STORE, LOAD, FETCH; each done pulse once.
REQ-023 Flush: clear on 2nd cycle of a FETCH -> no if_done, IDLE next cycle; clear during STORE -> store still completes, finish_store pulses.
REQ-024 Byte load at 0xFFFFFFFF = 0x80 -> ld_data = 0x00000080; halfword at 0xFFFFFFFF reads second byte from 0x00000000.
REQ-025 rdy low 3 cycles mid-STORE -> mem_wr 0 throughout, transfer resumes at same byte, memory image unchanged vs rdy-high run.
